// File: rtl/otter_csr_unit.sv
// Machine-mode CSR file and trap-state block for the OTTER core.
// Handles CSR read-modify-write, trap entry/mret bookkeeping, mcycle and the external IRQ synchronizer.
module otter_csr_unit #(
    parameter logic [31:0] RESET_MTVEC     = 32'h0000_0000,
    parameter int          IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic        intrpt_taken,
    input  logic        mret_exec,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] pc,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        intrpt_vld,
    output logic        illegal_csr
);

    logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [IRQ_SYNC_STAGES-1:0] sync_q, sync_d;

    logic        meip, hit, wr_en;
    logic [31:0] wval;

    assign meip = sync_q[IRQ_SYNC_STAGES-1];

    always_comb begin
        hit       = 1'b1;
        csr_rdata = 32'h0;
        case (csr_addr)
            12'h300: csr_rdata = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            12'h304: csr_rdata = {20'h0, meie_q, 11'h0};
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = {20'h0, meip, 11'h0};
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = csr_rdata | csr_wdata;
            2'b11:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    assign wr_en = csr_we && (csr_op != 2'b00) && hit;

    // Per-register priority: trap entry beats mret beats a CSR write.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        sync_d     = {sync_q[IRQ_SYNC_STAGES-2:0], ext_irq};

        if (intrpt_taken) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (mret_exec) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_en && csr_addr == 12'h300) begin
            mie_d  = wval[3];
            mpie_d = wval[7];
        end

        if (intrpt_taken)
            mepc_d = pc & 32'hFFFF_FFFC;
        else if (wr_en && csr_addr == 12'h341)
            mepc_d = wval & 32'hFFFF_FFFC;

        if (intrpt_taken)
            mcause_d = 32'h8000_000B;
        else if (wr_en && csr_addr == 12'h342)
            mcause_d = wval;

        if (wr_en && csr_addr == 12'h304) meie_d     = wval[11];
        if (wr_en && csr_addr == 12'h305) mtvec_d    = wval & 32'hFFFF_FFFC;
        if (wr_en && csr_addr == 12'h340) mscratch_d = wval;

        // A high-word write keeps the low word counting but drops its carry.
        if (wr_en && csr_addr == 12'hB00)
            mcycle_d = {mcycle_q[63:32], wval};
        else if (wr_en && csr_addr == 12'hB80)
            mcycle_d = {wval, mcycle_q[31:0] + 32'd1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC & 32'hFFFF_FFFC;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mcycle_q   <= 64'h0;
            sync_q     <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            sync_q     <= sync_d;
        end
    end

    assign mtvec_out   = mtvec_q;
    assign mepc_out    = mepc_q;
    assign intrpt_vld  = mie_q & meie_q & meip;
    assign illegal_csr = csr_we & ~hit;

endmodule

// File: tb/tb_otter_csr_unit.sv
// Bench for otter_csr_unit: directed walk through the CSR/trap flow, then randomized traffic
// compared every cycle against a register-level behavioural model.
module tb_otter_csr_unit;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rst, csr_we, intrpt_taken, mret_exec, ext_irq;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata, pc;
    logic [31:0] csr_rdata, mtvec_out, mepc_out;
    logic        intrpt_vld, illegal_csr;

    otter_csr_unit #(.RESET_MTVEC(32'h100), .IRQ_SYNC_STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .intrpt_taken(intrpt_taken),
        .mret_exec(mret_exec), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .pc(pc), .ext_irq(ext_irq),
        .csr_rdata(csr_rdata), .mtvec_out(mtvec_out), .mepc_out(mepc_out),
        .intrpt_vld(intrpt_vld), .illegal_csr(illegal_csr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endfunction

    // Model: architectural register words plus a history of sampled ext_irq levels.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle;
    bit          irq_hist[$];
    bit          model_ok = 0;

    function automatic bit m_meip();
        return irq_hist[$];
    endfunction

    function automatic bit mapped(logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80};
    endfunction

    function automatic logic [31:0] mread(logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_meip() ? 32'h800 : 32'h0;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] old_v, new_v, n_mstatus, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause;
    logic [63:0] n_cycle;

    always @(posedge clk) begin
        if (rst) begin
            m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_cycle = 0;
            irq_hist.delete();
            for (int i = 0; i < STAGES; i++) irq_hist.push_back(1'b0);
            model_ok = 1;
        end else if (model_ok) begin
            old_v = mread(csr_addr);
            case (csr_op)
                2'b01:   new_v = csr_wdata;
                2'b10:   new_v = old_v | csr_wdata;
                2'b11:   new_v = old_v & ~csr_wdata;
                default: new_v = old_v;
            endcase
            n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec;
            n_mscratch = m_mscratch; n_mepc = m_mepc; n_mcause = m_mcause;
            n_cycle = m_cycle + 1;
            // Apply lowest priority first so higher-priority events overwrite.
            if (csr_we && csr_op != 0 && mapped(csr_addr)) begin
                case (csr_addr)
                    12'h300: n_mstatus  = new_v & 32'h88;
                    12'h304: n_mie      = new_v & 32'h800;
                    12'h305: n_mtvec    = new_v & ~32'h3;
                    12'h340: n_mscratch = new_v;
                    12'h341: n_mepc     = new_v & ~32'h3;
                    12'h342: n_mcause   = new_v;
                    12'hB00: n_cycle    = {m_cycle[63:32], new_v};
                    12'hB80: n_cycle    = (64'(new_v) << 32) + ((m_cycle + 1) % 64'h1_0000_0000);
                    default: ;
                endcase
            end
            if (mret_exec)
                n_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            if (intrpt_taken) begin
                n_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
                n_mepc    = pc & ~32'h3;
                n_mcause  = 32'h8000_000B;
            end
            m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec;
            m_mscratch = n_mscratch; m_mepc = n_mepc; m_mcause = n_mcause;
            m_cycle = n_cycle;
            irq_hist.push_front(ext_irq);
            void'(irq_hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("rdata",   csr_rdata,   mread(csr_addr));
            chk("mtvec",   mtvec_out,   m_mtvec);
            chk("mepc",    mepc_out,    m_mepc);
            chk("vld",     intrpt_vld,  m_mstatus[3] & m_mie[11] & m_meip());
            chk("illegal", illegal_csr, csr_we & ~mapped(csr_addr));
        end
    end

    task automatic idle();
        csr_we = 0; intrpt_taken = 0; mret_exec = 0; csr_op = 2'b00;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic commit();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic wr(logic [11:0] a, logic [1:0] op, logic [31:0] d);
        csr_we = 1; csr_addr = a; csr_op = op; csr_wdata = d;
    endtask

    task automatic rd_chk(string name, logic [11:0] a, logic [31:0] exp);
        csr_addr = a; #1;
        chk(name, csr_rdata, exp);
    endtask

    logic [11:0] addr_tab[12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h301, 12'hFFF};

    initial begin
        rst = 1; idle(); ext_irq = 0; csr_addr = 0; csr_wdata = 0; pc = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        settle();
        rd_chk("rst_mtvec", 12'h305, 32'h100);
        rd_chk("rst_mstatus", 12'h300, 32'h0);
        chk("rst_vld", intrpt_vld, 1'b0);
        chk("rst_illegal", illegal_csr, 1'b0);

        @(posedge clk); #1;
        wr(12'h340, 2'b01, 32'hDEAD_BEEF); commit();
        wr(12'h340, 2'b11, 32'h0000_FFFF); settle();
        chk("rc_old", csr_rdata, 32'hDEAD_BEEF);
        commit();
        rd_chk("rc_new", 12'h340, 32'hDEAD_0000);

        wr(12'h300, 2'b01, 32'h8); commit();
        wr(12'h304, 2'b01, 32'h800); commit();
        ext_irq = 1; settle();
        chk("vld_pre", intrpt_vld, 1'b0);
        commit();
        chk("vld_k", intrpt_vld, 1'b0);
        commit();
        chk("vld_k1", intrpt_vld, 1'b1);

        intrpt_taken = 1; pc = 32'h1234; commit();
        chk("trap_mepc", mepc_out, 32'h1234);
        chk("trap_vld", intrpt_vld, 1'b0);
        rd_chk("trap_mcause", 12'h342, 32'h8000_000B);
        rd_chk("trap_mstatus", 12'h300, 32'h80);

        mret_exec = 1; commit();
        rd_chk("mret_mstatus", 12'h300, 32'h88);
        chk("mret_vld", intrpt_vld, 1'b1);

        wr(12'hB00, 2'b01, 32'hFFFF_FFFF); commit();
        rd_chk("cyc_lo_wr", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("cyc_hi_wr", 12'hB80, 32'h0);
        @(posedge clk); #1;
        rd_chk("cyc_hi", 12'hB80, 32'h1);
        rd_chk("cyc_lo", 12'hB00, 32'h0);

        wr(12'h7C0, 2'b01, 32'h1234_5678); #1;
        chk("illegal_set", illegal_csr, 1'b1);
        chk("illegal_rdata", csr_rdata, 32'h0);
        commit();
        rd_chk("illegal_nochg", 12'h340, 32'hDEAD_0000);

        wr(12'h341, 2'b01, 32'h40); intrpt_taken = 1; pc = 32'h200; commit();
        chk("prio_mepc", mepc_out, 32'h200);

        wr(12'h340, 2'b01, 32'h55); intrpt_taken = 1; pc = 32'h302; commit();
        chk("both_mepc", mepc_out, 32'h300);
        rd_chk("both_mscratch", 12'h340, 32'h55);

        wr(12'hB80, 2'b01, 32'hFFFF_FFFF); commit();
        wr(12'hB00, 2'b01, 32'hFFFF_FFFE); commit();
        @(posedge clk); #1;
        rd_chk("wrap_pre", 12'hB80, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd_chk("wrap_hi", 12'hB80, 32'h0);
        rd_chk("wrap_lo", 12'hB00, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst          = ($urandom_range(0, 199) == 0);
            csr_we       = $urandom_range(0, 1);
            intrpt_taken = ($urandom_range(0, 7) == 0);
            mret_exec    = ($urandom_range(0, 7) == 0);
            csr_addr     = addr_tab[$urandom_range(0, 11)];
            csr_op       = 2'($urandom_range(0, 3));
            csr_wdata    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            pc           = $urandom;
            if ($urandom_range(0, 3) == 0) ext_irq = ~ext_irq;
        end
        @(posedge clk); #1;
        rst = 0; idle();
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
